// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with per-register busy scoreboard.
// Destinations are reserved at issue and released by write-back so readers can see pending results.
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] read_address_0,
    input  logic [ADDR_WIDTH-1:0] read_address_1,
    output logic [DATA_WIDTH-1:0] read_data_0,
    output logic [DATA_WIDTH-1:0] read_data_1,
    output logic                  busy_0,
    output logic                  busy_1,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_address_0,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  reserve_en,
    input  logic [ADDR_WIDTH-1:0] reserve_address,
    output logic                  reserve_conflict
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy;

    logic write_ok;
    logic reserve_ok;
    logic hit_0;
    logic hit_1;
    logic zero_0;
    logic zero_1;
    logic conflict_next;

    always_comb begin
        // Register 0 swallows writes and reservations when hardwired to zero.
        write_ok   = write_en && !(ZERO_REG && (write_address_0 == '0));
        reserve_ok = reserve_en && !(ZERO_REG && (reserve_address == '0));

        // Forwarding is gated by rst_n so outputs read as zero throughout reset.
        hit_0  = BYPASS && rst_n && write_ok && (write_address_0 == read_address_0);
        hit_1  = BYPASS && rst_n && write_ok && (write_address_0 == read_address_1);
        zero_0 = ZERO_REG && (read_address_0 == '0);
        zero_1 = ZERO_REG && (read_address_1 == '0);

        read_data_0 = zero_0 ? '0 : (hit_0 ? write_data : regs[read_address_0]);
        read_data_1 = zero_1 ? '0 : (hit_1 ? write_data : regs[read_address_1]);
        busy_0      = busy[read_address_0] && !hit_0 && !zero_0;
        busy_1      = busy[read_address_1] && !hit_1 && !zero_1;

        // A write-back to the same register in the same cycle releases it, so no conflict.
        conflict_next = reserve_ok && busy[reserve_address]
                        && !(write_en && (write_address_0 == reserve_address));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (write_ok) begin
            regs[write_address_0] <= write_data;
        end
    end

    // Reserve is applied after the release so a same-edge reservation wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy             <= '0;
            reserve_conflict <= 1'b0;
        end else begin
            reserve_conflict <= conflict_next;
            if (write_ok) begin
                busy[write_address_0] <= 1'b0;
            end
            if (reserve_ok) begin
                busy[reserve_address] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed table, bypass-off instance, random model run, reset corners.
module tb_regfile_scoreboard;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int W  = 2 * DW + 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] read_address_0 = '0;
    logic [AW-1:0] read_address_1 = '0;
    logic          write_en = 1'b0;
    logic [AW-1:0] write_address_0 = '0;
    logic [DW-1:0] write_data = '0;
    logic          reserve_en = 1'b0;
    logic [AW-1:0] reserve_address = '0;

    logic [DW-1:0] read_data_0, read_data_1, nb_read_data_0, nb_read_data_1;
    logic          busy_0, busy_1, nb_busy_0, nb_busy_1;
    logic          reserve_conflict, nb_reserve_conflict;

    always #5 clk = ~clk;

    regfile_scoreboard #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .read_address_0(read_address_0), .read_address_1(read_address_1),
        .read_data_0(read_data_0), .read_data_1(read_data_1),
        .busy_0(busy_0), .busy_1(busy_1),
        .write_en(write_en), .write_address_0(write_address_0), .write_data(write_data),
        .reserve_en(reserve_en), .reserve_address(reserve_address),
        .reserve_conflict(reserve_conflict)
    );

    regfile_scoreboard #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n),
        .read_address_0(read_address_0), .read_address_1(read_address_1),
        .read_data_0(nb_read_data_0), .read_data_1(nb_read_data_1),
        .busy_0(nb_busy_0), .busy_1(nb_busy_1),
        .write_en(write_en), .write_address_0(write_address_0), .write_data(write_data),
        .reserve_en(reserve_en), .reserve_address(reserve_address),
        .reserve_conflict(nb_reserve_conflict)
    );

    // Expected output records: {read_data_0, read_data_1, busy_0, busy_1, reserve_conflict}.
    logic [W-1:0] exp_q[$];
    logic [W-1:0] nb_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          re;
        logic [AW-1:0] ra;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [DW-1:0] e_rd0;
        logic [DW-1:0] e_rd1;
        logic          e_b0;
        logic          e_b1;
        logic          e_conf;
    } vec_t;

    vec_t vecs[19];

    logic [DW-1:0] m_regs[2**AW];
    logic [2**AW-1:0] m_busy;
    logic m_conf;

    function automatic logic [W-1:0] pack(input logic [DW-1:0] rd0, input logic [DW-1:0] rd1,
                                          input logic b0, input logic b1, input logic c);
        return {rd0, rd1, b0, b1, c};
    endfunction

    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic re, input logic [AW-1:0] ra,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        @(negedge clk);
        write_en        = we;
        write_address_0 = wa;
        write_data      = wd;
        reserve_en      = re;
        reserve_address = ra;
        read_address_0  = a0;
        read_address_1  = a1;
    endtask

    task automatic compare(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got rd0=%h rd1=%h busy=%b%b conflict=%b, expected rd0=%h rd1=%h busy=%b%b conflict=%b",
                     name, got[W-1 -: DW], got[DW+2 -: DW], got[2], got[1], got[0],
                     want[W-1 -: DW], want[DW+2 -: DW], want[2], want[1], want[0]);
        end
    endtask

    task automatic check(input string name, input logic [W-1:0] want);
        exp_q.push_back(want);
        #1;
        compare(name, {read_data_0, read_data_1, busy_0, busy_1, reserve_conflict}, exp_q.pop_front());
    endtask

    task automatic check_nb(input string name, input logic [W-1:0] want);
        nb_q.push_back(want);
        compare(name, {nb_read_data_0, nb_read_data_1, nb_busy_0, nb_busy_1, nb_reserve_conflict},
                nb_q.pop_front());
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        write_en = 1'b0;
        reserve_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // we wa wd re ra a0 a1 | rd0 rd1 b0 b1 conf
        vecs[0]  = '{1'b1, 5'd7,  32'hDEADBEEF, 1'b0, 5'd0,  5'd7,  5'd9,  32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd7,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 5'd9,  32'h12345678, 1'b0, 5'd0,  5'd7,  5'd9,  32'hDEADBEEF, 32'h12345678, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  5'd0,  5'd9,  32'h0, 32'h12345678, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd0,  5'd0,  32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  5'd5,  5'd0,  32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  5'd5,  32'h0, 32'h0, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 5'd5,  32'hA5,       1'b0, 5'd0,  5'd5,  5'd5,  32'hA5, 32'hA5, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  5'd0,  32'hA5, 32'h0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  5'd5,  5'd0,  32'hA5, 32'h0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  5'd5,  5'd0,  32'hA5, 32'h0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  5'd0,  32'hA5, 32'h0, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  5'd12, 32'hA5, 32'h0, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 5'd12, 32'hCAFEF00D, 1'b1, 5'd12, 5'd12, 5'd5,  32'hCAFEF00D, 32'hA5, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd12, 5'd12, 32'hCAFEF00D, 32'hCAFEF00D, 1'b1, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 5'd12, 32'h11,       1'b1, 5'd12, 5'd12, 5'd5,  32'h11, 32'hA5, 1'b0, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd12, 5'd5,  32'h11, 32'hA5, 1'b1, 1'b1, 1'b0};
        vecs[17] = '{1'b1, 5'd5,  32'h55,       1'b0, 5'd0,  5'd5,  5'd12, 32'h55, 32'h11, 1'b0, 1'b1, 1'b0};
        vecs[18] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  5'd12, 32'h55, 32'h11, 1'b0, 1'b1, 1'b0};

        // Reset held: every address reads zero, and writes/reserves (with bypass) are ignored.
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, AW'(i), $urandom, 1'b1, AW'(i), AW'(i), AW'(31 - i));
            check($sformatf("reset_read_%0d", i), pack(32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        write_en = 1'b0;
        reserve_en = 1'b0;
        read_address_0 = 5'd7;
        read_address_1 = 5'd31;
        check("reset_release", pack(32'h0, 32'h0, 1'b0, 1'b0, 1'b0));

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra, vecs[i].a0, vecs[i].a1);
            check($sformatf("vec_%0d", i),
                  pack(vecs[i].e_rd0, vecs[i].e_rd1, vecs[i].e_b0, vecs[i].e_b1, vecs[i].e_conf));
        end

        // Without bypass the old value shows until the edge.
        drive(1'b1, 5'd20, 32'h12345678, 1'b0, 5'd0, 5'd20, 5'd20);
        check("bypass_on_write", pack(32'h12345678, 32'h12345678, 1'b0, 1'b0, 1'b0));
        check_nb("bypass_off_write", pack(32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd20, 5'd20);
        check("bypass_on_after", pack(32'h12345678, 32'h12345678, 1'b0, 1'b0, 1'b0));
        check_nb("bypass_off_after", pack(32'h12345678, 32'h12345678, 1'b0, 1'b0, 1'b0));

        // Random traffic against a reference model, both bypass variants.
        do_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_busy = '0;
        m_conf = 1'b0;
        for (int n = 0; n < 300; n++) begin
            logic          we, re, h0, h1;
            logic [AW-1:0] wa, ra, a0, a1;
            logic [DW-1:0] wd, e0, e1, n0, n1;
            we = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            wa = AW'($urandom_range(0, 7));
            ra = AW'($urandom_range(0, 7));
            a0 = AW'($urandom_range(0, 7));
            a1 = AW'($urandom_range(0, 7));
            wd = $urandom;
            drive(we, wa, wd, re, ra, a0, a1);
            h0 = we && (wa != 0) && (wa == a0);
            h1 = we && (wa != 0) && (wa == a1);
            n0 = (a0 == 0) ? 32'h0 : m_regs[a0];
            n1 = (a1 == 0) ? 32'h0 : m_regs[a1];
            e0 = h0 ? wd : n0;
            e1 = h1 ? wd : n1;
            check($sformatf("rand_%0d", n), pack(e0, e1, m_busy[a0] && !h0, m_busy[a1] && !h1, m_conf));
            check_nb($sformatf("rand_nb_%0d", n), pack(n0, n1, m_busy[a0], m_busy[a1], m_conf));
            m_conf = re && (ra != 0) && m_busy[ra] && !(we && (wa == ra));
            if (we && (wa != 0)) begin
                m_regs[wa] = wd;
                m_busy[wa] = 1'b0;
            end
            if (re && (ra != 0)) m_busy[ra] = 1'b1;
        end

        // Reset asserted mid-cycle clears pending reservations, data and the conflict pulse at once.
        do_reset();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd4);
        check("mid_res3", pack(32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd3, 5'd4);
        check("mid_res4", pack(32'h0, 32'h0, 1'b1, 1'b0, 1'b0));
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 5'd3, 5'd4);
        check("mid_write3", pack(32'h33, 32'h0, 1'b0, 1'b1, 1'b0));
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd4);
        check("mid_pre_reset", pack(32'h33, 32'h0, 1'b0, 1'b1, 1'b1));
        #2;
        rst_n = 1'b0;
        write_en = 1'b1;
        write_address_0 = 5'd3;
        write_data = 32'h77;
        check("mid_in_reset", pack(32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        write_en = 1'b0;
        check("mid_post_reset", pack(32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd4);
        check("mid_settled", pack(32'h0, 32'h0, 1'b0, 1'b0, 1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
